// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and default bit period.
// The FSM enum takes its values from the ST_* constants, so both always share one encoding.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_CLK_PER_BIT_DEF = 868;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO; dout is valid whenever empty is low.
// Any push or pop takes effect at the next edge. The caller must not push when full unless it also pops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (we) wr_ptr_d = wr_ptr_q + AW'(1);
    if (re) rd_ptr_d = rd_ptr_q + AW'(1);
    if (we && !re)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!we && re) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: first start bit one edge after a push into an idle, empty block; frames are 10*CLK_PER_BIT cycles.
// No backpressure: a strobe that finds the FIFO full with no pop at the same edge drops the byte and sets a sticky overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEF,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] sdata,
  input  logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          overflow_q, overflow_d;

  logic       pop;
  logic       push_ok;
  logic       bit_end;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .we    (push_ok),
    .din   (sdata),
    .re    (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bit_end = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    push_ok    = tx_ready && (!fifo_full || pop);
    overflow_d = overflow_q || (tx_ready && !push_ok);

    // Line level for the cycle after this edge, so txd comes straight off a flop.
    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign txd      = txd_q;
  assign busy     = (state_q != S_IDLE) || !fifo_empty;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-and-frame-timer reference model plus a line decoder on txd.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEP   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] sdata;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic       full;
  logic       overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sdata    (sdata),
    .tx_ready (tx_ready),
    .txd      (txd),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting, the byte on the line and cycles left in its frame.
  logic [7:0] q_m[$];
  logic [7:0] sent_exp[$];
  logic [7:0] dec_q[$];
  logic [7:0] exp_l[$];
  logic [7:0] cur_m = 8'h00;
  int         rem_m = 0;
  logic       ovf_m = 1'b0;

  bit         dec_on  = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_txd();
    int pos;
    if (rem_m == 0) return 1'b1;
    pos = FRAME - rem_m;
    if (pos < CPB) return 1'b0;
    if (pos < 9 * CPB) return cur_m[3'((pos - CPB) / CPB)];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rn, input logic tr, input logic [7:0] d);
    bit pop, acc;
    if (!rn) begin
      q_m.delete();
      rem_m = 0;
      ovf_m = 1'b0;
      return;
    end
    pop = (rem_m <= 1) && (q_m.size() > 0);
    acc = 1'b0;
    if (tr) begin
      if (q_m.size() < DEP || pop) acc = 1'b1;
      else ovf_m = 1'b1;
    end
    if (rem_m == 1) sent_exp.push_back(cur_m);
    if (pop) begin
      cur_m = q_m.pop_front();
      rem_m = FRAME;
    end else if (rem_m > 0) begin
      rem_m--;
    end
    if (acc) q_m.push_back(d);
  endtask

  task automatic decode(input logic rn);
    if (!rn) begin
      dec_on = 1'b0;
      return;
    end
    if (!dec_on) begin
      if (txd == 1'b0) begin
        dec_on  = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= CPB && dec_cnt < 9 * CPB && (dec_cnt % CPB) == CPB / 2)
        dec_byte[3'((dec_cnt - CPB) / CPB)] = txd;
      if (dec_cnt == 9 * CPB + CPB / 2) begin
        chk("stop_bit", txd, 1);
        dec_q.push_back(dec_byte);
      end
      if (dec_cnt == FRAME - 1) dec_on = 1'b0;
    end
  endtask

  task automatic step(input logic rn, input logic tr, input logic [7:0] d);
    rstn     = rn;
    tx_ready = tr;
    sdata    = d;
    @(posedge clk);
    model_edge(rn, tr, d);
    #1;
    chk("txd", txd, exp_txd());
    chk("busy", busy, (rem_m > 0) || (q_m.size() > 0));
    chk("full", full, q_m.size() == DEP);
    chk("overflow", overflow, ovf_m);
    decode(rn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  // Decoded line bytes against both the model's completed frames and a directed list.
  task automatic check_bytes(input string tag);
    chk({tag, "_count_model"}, dec_q.size(), sent_exp.size());
    chk({tag, "_count_list"}, dec_q.size(), exp_l.size());
    for (int i = 0; i < dec_q.size() && i < sent_exp.size(); i++)
      chk({tag, "_byte_model"}, dec_q[i], sent_exp[i]);
    for (int i = 0; i < dec_q.size() && i < exp_l.size(); i++)
      chk({tag, "_byte_list"}, dec_q[i], exp_l[i]);
    dec_q.delete();
    sent_exp.delete();
    exp_l.delete();
  endtask

  initial begin
    int k;
    rstn = 1'b0; tx_ready = 1'b0; sdata = 8'h00;

    // Reset state
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hEE);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);

    // Single byte: start bit on the next edge, busy drops 41 edges after the push
    step(1'b1, 1'b1, 8'h55);
    chk("s1_busy_rise", busy, 1);
    chk("s1_txd_still_high", txd, 1);
    step(1'b1, 1'b0, 8'h00);
    chk("s1_start_bit", txd, 0);
    idle(39);
    chk("s1_busy_last", busy, 1);
    step(1'b1, 1'b0, 8'h00);
    chk("s1_busy_fall", busy, 0);
    idle(4);
    exp_l = {8'h55};
    check_bytes("single");

    // Back-to-back
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hA5);
    idle(125);
    exp_l = {8'h00, 8'hFF, 8'hA5};
    check_bytes("b2b");

    // Overflow: the sixth byte is dropped
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 8'(i));
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    idle(5 * FRAME + 10);
    chk("ovf_sticky", overflow, 1);
    exp_l = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_bytes("ovf");

    // Push at full on the STOP-end pop edge
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hA1);
    step(1'b1, 1'b1, 8'hB2);
    step(1'b1, 1'b1, 8'hC3);
    step(1'b1, 1'b1, 8'hD4);
    step(1'b1, 1'b1, 8'hE5);
    chk("pf_full_before", full, 1);
    k = 0;
    while (rem_m != 1 && k < 200) begin
      step(1'b1, 1'b0, 8'h00);
      k++;
    end
    chk("pf_stop_end_reached", k < 200, 1);
    step(1'b1, 1'b1, 8'hF6);
    chk("pf_full_after", full, 1);
    chk("pf_no_ovf", overflow, 0);
    idle(6 * FRAME + 10);
    exp_l = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    check_bytes("pushfull");

    // Reset in the middle of a frame discards everything
    step(1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b1, 8'h22);
    idle(12);
    chk("mr_in_frame", busy, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("mr_txd", txd, 1);
    chk("mr_busy", busy, 0);
    chk("mr_ovf", overflow, 0);
    idle(3 * FRAME);
    chk("mr_line_quiet", txd, 1);
    check_bytes("midreset");

    // Console bytes as the core would send them
    step(1'b1, 1'b1, 8'h48);
    idle(7);
    step(1'b1, 1'b1, 8'h69);
    idle(2 * FRAME + 10);
    exp_l = {8'h48, 8'h69};
    check_bytes("hi");

    // Random strobes and bursts, with a rare reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        step(1'b0, 1'b0, 8'h00);
      end else if ($urandom_range(0, 199) == 0) begin
        for (int j = 0; j < 6; j++) step(1'b1, 1'b1, 8'($urandom));
      end else begin
        step(1'b1, ($urandom_range(0, 24) == 0), 8'($urandom));
      end
    end
    idle(DEP * FRAME + 2 * FRAME);
    chk("rand_drained", busy, 0);
    chk("rand_count", dec_q.size(), sent_exp.size());
    for (int i = 0; i < dec_q.size() && i < sent_exp.size(); i++)
      chk("rand_byte", dec_q[i], sent_exp[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
